// File: rtl/evt_sync_arb_pkg.sv
// Shared definitions for the event-synchronizer arbiter: FSM state encoding and its width.
package evt_sync_pkg;

  localparam int STATE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 1'b0,
    S_WAIT_ACK = 1'b1
  } state_t;

endpackage

// File: rtl/evt_sync_arb_if.sv
// Event/channel bundle of evt_sync_arb: requesters and ack on one side, channel and status on the other.
interface evt_sync_arb_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);

  logic [N-1:0]   req_pulse;
  logic           ack_pulse;
  logic           chan_tgl;
  logic [IDW-1:0] chan_id;
  logic           busy;
  logic [N-1:0]   done_pulse;
  logic [N-1:0]   ovf_pulse;
  logic           err_pulse;

  modport master (
    output req_pulse, ack_pulse,
    input  chan_tgl, chan_id, busy, done_pulse, ovf_pulse, err_pulse
  );

  modport slave (
    input  req_pulse, ack_pulse,
    output chan_tgl, chan_id, busy, done_pulse, ovf_pulse, err_pulse
  );

endinterface

// File: rtl/evt_sync_arb_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or after i_ptr, wrapping at N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_pending,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic          w_found;
  int            w_j;
  logic [IW-1:0] w_j_idx;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    w_j_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      w_j_idx = IW'(w_j);
      if (!w_found && i_pending[w_j_idx]) begin
        w_found        = 1'b1;
        o_gnt[w_j_idx] = 1'b1;
        o_idx          = w_j_idx;
      end
    end
  end

endmodule

// File: rtl/evt_sync_arb.sv
// Arbitrates N one-cycle event sources onto one shared toggle-based CDC channel.
// Optional ack watchdog enabled by defining EVT_SYNC_ARB_TIMEOUT_EN.
module evt_sync_arb
  import evt_sync_pkg::*;
#(
  parameter int N           = 4,
  parameter int IDW         = 2,
  parameter bit DEFAULT_VAL = 1'b0,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk,
  input  logic          rstn,
  evt_sync_arb_if.slave bus
);

  if (N < 2 || N > 16 || IDW != $clog2(N) || TIMEOUT < 2) begin : g_param_check
    $error("evt_sync_arb: illegal parameter combination");
  end

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_pending;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_chan_id;
  logic           r_chan_tgl;
  logic [N-1:0]   r_done;
  logic [N-1:0]   r_ovf;

  logic [N-1:0]   w_gnt;
  logic [IDW-1:0] w_gnt_idx;
  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_done_vec;
  logic           w_launch;
  logic           w_ack_done;
  logic           w_tmo;

  rr_pick #(.N(N)) u_rr_pick (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_idx     (w_gnt_idx)
  );

`ifdef EVT_SYNC_ARB_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_ack_done  = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_launch    = 1'b1;
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // An ack in the watchdog's final cycle takes precedence over the abort.
        if (bus.ack_pulse) begin
          w_ack_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef EVT_SYNC_ARB_TIMEOUT_EN
        else if (r_tmo_cnt == TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_clr                 = w_launch ? w_gnt : '0;
    w_done_vec            = '0;
    w_done_vec[r_chan_id] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending  <= '0;
      r_ptr      <= '0;
      r_chan_id  <= '0;
      r_chan_tgl <= DEFAULT_VAL;
      r_done     <= '0;
      r_ovf      <= '0;
    end else begin
      // A request coinciding with its own launch re-arms pending instead of overflowing.
      r_pending <= (r_pending & ~w_clr) | bus.req_pulse;
      r_ovf     <= bus.req_pulse & r_pending & ~w_clr;
      r_done    <= w_ack_done ? w_done_vec : '0;
      if (w_launch) begin
        r_chan_id  <= w_gnt_idx;
        r_chan_tgl <= ~r_chan_tgl;
        r_ptr      <= (w_gnt_idx == IDW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

`ifdef EVT_SYNC_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_tmo;
      if (w_launch) begin
        r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT_ACK) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign bus.err_pulse = r_err;
`else
  assign bus.err_pulse = 1'b0;
`endif

  assign bus.chan_tgl   = r_chan_tgl;
  assign bus.chan_id    = r_chan_id;
  assign bus.busy       = (r_state == S_WAIT_ACK);
  assign bus.done_pulse = r_done;
  assign bus.ovf_pulse  = r_ovf;

endmodule

// File: tb/tb_evt_sync_arb.sv
// Scoreboard bench for evt_sync_arb: stimulus queues expected launches/dones/overflows/errors,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_evt_sync_arb;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef EVT_SYNC_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  evt_sync_arb_if #(.N(N), .IDW(IDW)) bus ();

  evt_sync_arb #(
    .N           (N),
    .IDW         (IDW),
    .DEFAULT_VAL (1'b0),
    .TIMEOUT     (TMO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int           checks   = 0;
  int           failures = 0;
  int           toggles  = 0;
  int           exp_err  = 0;
  int           exp_launch[$];
  logic [N-1:0] exp_done[$];
  logic [N-1:0] exp_ovf[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares every launch (toggle), done, overflow and error against the queues.
  initial begin
    logic         prev_tgl;
    int           e;
    logic [N-1:0] ev;
    prev_tgl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_tgl = bus.chan_tgl;
      end else begin
        if (bus.chan_tgl !== prev_tgl) begin
          toggles++;
          e = (exp_launch.size() > 0) ? exp_launch.pop_front() : -1;
          check("launch_id", 32'(bus.chan_id), e);
          check("launch_busy", 32'(bus.busy), 1);
          prev_tgl = bus.chan_tgl;
        end
        if (bus.done_pulse !== '0) begin
          ev = (exp_done.size() > 0) ? exp_done.pop_front() : '0;
          check("done_pulse", 32'(bus.done_pulse), 32'(ev));
        end
        if (bus.ovf_pulse !== '0) begin
          ev = (exp_ovf.size() > 0) ? exp_ovf.pop_front() : '0;
          check("ovf_pulse", 32'(bus.ovf_pulse), 32'(ev));
        end
        if (bus.err_pulse !== 1'b0) begin
          check("err_pulse", 32'(bus.err_pulse), 32'(exp_err > 0));
          if (exp_err > 0) exp_err--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_tgl"},  32'(bus.chan_tgl),   0);
    check({name, "_id"},   32'(bus.chan_id),    0);
    check({name, "_busy"}, 32'(bus.busy),       0);
    check({name, "_done"}, 32'(bus.done_pulse), 0);
    check({name, "_ovf"},  32'(bus.ovf_pulse),  0);
    check({name, "_err"},  32'(bus.err_pulse),  0);
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    bus.req_pulse = '0;
    bus.ack_pulse = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    rstn = 1'b1;
    tick();
  endtask

  task automatic pulse_req(input logic [N-1:0] v);
    bus.req_pulse = v;
    tick();
    bus.req_pulse = '0;
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({name, "_busy_wait"}, 32'(bus.busy), 1);
  endtask

  task automatic send_ack(input logic [N-1:0] d);
    exp_done.push_back(d);
    bus.ack_pulse = 1'b1;
    tick();
    bus.ack_pulse = 1'b0;
    check("ack_busy_clr", 32'(bus.busy), 0);
  endtask

  initial begin
    int           tbase;
    logic [N-1:0] d;
    logic [N-1:0] s2_done [3];
    s2_done[0] = 4'b0001;
    s2_done[1] = 4'b0010;
    s2_done[2] = 4'b1000;
    bus.req_pulse = '0;
    bus.ack_pulse = 1'b0;

    // Single event: two-cycle launch latency, done to the right requester.
    do_reset();
    exp_launch.push_back(2);
    pulse_req(4'b0100);
    check("s1_no_early_tgl", 32'(bus.chan_tgl), 0);
    check("s1_no_early_busy", 32'(bus.busy), 0);
    tick();
    check("s1_tgl", 32'(bus.chan_tgl), 1);
    check("s1_id", 32'(bus.chan_id), 2);
    check("s1_busy", 32'(bus.busy), 1);
    tick();
    tick();
    check("s1_tgl_stable", 32'(bus.chan_tgl), 1);
    check("s1_id_stable", 32'(bus.chan_id), 2);
    send_ack(4'b0100);
    tick();
    check("s1_no_relaunch", 32'(bus.busy), 0);
    // Ack while idle must be ignored.
    bus.ack_pulse = 1'b1;
    tick();
    bus.ack_pulse = 1'b0;
    check("idle_ack_done", 32'(bus.done_pulse), 0);
    check("idle_ack_busy", 32'(bus.busy), 0);
    tick();

    // Simultaneous events: grants 0, 1, 3 with exactly three toggles.
    do_reset();
    tbase = toggles;
    exp_launch.push_back(0);
    exp_launch.push_back(1);
    exp_launch.push_back(3);
    pulse_req(4'b1011);
    for (int k = 0; k < 3; k++) begin
      wait_busy("s2");
      send_ack(s2_done[k]);
    end
    repeat (4) tick();
    check("s2_toggles", 32'(toggles - tbase), 3);

    // Fairness: 0 and 3 re-request on done, grants alternate.
    do_reset();
    exp_launch.push_back(0);
    exp_launch.push_back(3);
    exp_launch.push_back(0);
    exp_launch.push_back(3);
    pulse_req(4'b1001);
    for (int r = 0; r < 4; r++) begin
      wait_busy("s3");
      d = (r % 2 == 0) ? 4'b0001 : 4'b1000;
      send_ack(d);
      if (r < 2) pulse_req(d);
    end
    repeat (4) tick();
    check("s3_idle_end", 32'(bus.busy), 0);

    // Overflow: second request for 1 while it is pending and channel is busy.
    do_reset();
    exp_launch.push_back(0);
    exp_launch.push_back(1);
    pulse_req(4'b0001);
    tick();
    check("s4_busy0", 32'(bus.busy), 1);
    pulse_req(4'b0010);
    exp_ovf.push_back(4'b0010);
    pulse_req(4'b0010);
    tick();
    send_ack(4'b0001);
    wait_busy("s4");
    check("s4_id1", 32'(bus.chan_id), 1);
    send_ack(4'b0010);
    repeat (4) tick();
    check("s4_single_launch", 32'(bus.busy), 0);

    // Request coinciding with its own launch: re-armed, no overflow.
    do_reset();
    exp_launch.push_back(1);
    exp_launch.push_back(1);
    pulse_req(4'b0010);
    pulse_req(4'b0010);
    check("s4b_busy", 32'(bus.busy), 1);
    send_ack(4'b0010);
    wait_busy("s4b");
    send_ack(4'b0010);
    repeat (3) tick();
    check("s4b_idle", 32'(bus.busy), 0);

`ifdef EVT_SYNC_ARB_TIMEOUT_EN
    // Watchdog abort eight cycles after launch.
    do_reset();
    exp_launch.push_back(2);
    pulse_req(4'b0100);
    tick();
    repeat (7) tick();
    check("s5_busy_pre", 32'(bus.busy), 1);
    check("s5_err_pre", 32'(bus.err_pulse), 0);
    exp_err = 1;
    tick();
    check("s5_err", 32'(bus.err_pulse), 1);
    check("s5_busy_post", 32'(bus.busy), 0);
    tick();
    check("s5_err_one_cycle", 32'(bus.err_pulse), 0);
    // Ack in the final watchdog cycle wins.
    exp_launch.push_back(2);
    pulse_req(4'b0100);
    tick();
    repeat (7) tick();
    send_ack(4'b0100);
    check("s5_ack_wins_err", 32'(bus.err_pulse), 0);
    repeat (2) tick();
`else
    // Without the watchdog the channel waits indefinitely.
    do_reset();
    exp_launch.push_back(2);
    pulse_req(4'b0100);
    tick();
    repeat (100) tick();
    check("s5_busy_hold", 32'(bus.busy), 1);
    check("s5_err_zero", 32'(bus.err_pulse), 0);
`endif

    // Reset mid-transfer discards transfer and pending work.
    do_reset();
    exp_launch.push_back(3);
    pulse_req(4'b1000);
    tick();
    check("s6_busy", 32'(bus.busy), 1);
    pulse_req(4'b0001);
    rstn = 1'b0;
    #2;
    check_reset_vals("s6_async");
    tick();
    rstn = 1'b1;
    tick();
    bus.ack_pulse = 1'b1;
    tick();
    bus.ack_pulse = 1'b0;
    check("s6_late_ack_done", 32'(bus.done_pulse), 0);
    repeat (3) tick();
    check("s6_no_launch", 32'(bus.busy), 0);
    check("s6_tgl", 32'(bus.chan_tgl), 0);

    check("q_launch_left", 32'(exp_launch.size()), 0);
    check("q_done_left", 32'(exp_done.size()), 0);
    check("q_ovf_left", 32'(exp_ovf.size()), 0);
    check("q_err_left", 32'(exp_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
